// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: MD opcodes, idle code, default latencies.
package mdu_pkg;

    localparam logic [3:0] MULT   = 4'd0;
    localparam logic [3:0] MULTU  = 4'd1;
    localparam logic [3:0] DIV    = 4'd2;
    localparam logic [3:0] DIVU   = 4'd3;
    localparam logic [3:0] MFHI   = 4'd4;
    localparam logic [3:0] MFLO   = 4'd5;
    localparam logic [3:0] MTHI   = 4'd6;
    localparam logic [3:0] MTLO   = 4'd7;
    // The MDU acts on MDOp whenever idle, so the idle code must not alias MULT (0).
    localparam logic [3:0] MD_NOP = 4'hF;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op <= DIVU;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_shadow_cnt.sv
// Shadow latency counter: loads on an accepted start, counts down, busy while non-zero.
module mdu_shadow_cnt
    import mdu_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy,
    output logic             restart
);

    logic [CNT_W-1:0] cnt;

    // A load while still counting is ignored; the caller flags it via restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load && (cnt == '0)) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy    = (cnt != '0);
    assign restart = load & busy;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage initiator for the MDU start/MDOp/Busy interface, with shadow busy tracking and stall.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_md_valid,
    input  logic [3:0] d_md_op,
    input  logic       d_advance,
    input  logic       e_flush,
    input  logic       mdu_busy,
    output logic [3:0] md_op,
    output logic       start,
    output logic       stall_md,
    output logic       err_sync
);

    // Handshake: start is a level held while E holds MULT/MULTU/DIV/DIVU; the MDU
    // samples it at the edge when idle and raises Busy from the following cycle
    // for the op's latency. Stalling MD-class work in D keeps start one cycle wide.
    logic       e_vld;
    logic [3:0] e_op;
    logic       shadow_busy;
    logic       restart;
    logic [CNT_W-1:0] load_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_vld <= 1'b0;
            e_op  <= MD_NOP;
        end else if (e_flush || stall_md) begin
            e_vld <= 1'b0;
            e_op  <= MD_NOP;
        end else if (d_advance) begin
            e_vld <= d_md_valid;
            e_op  <= d_md_valid ? d_md_op : MD_NOP;
        end
    end

    assign md_op    = e_vld ? e_op : MD_NOP;
    assign start    = e_vld & is_muldiv(e_op);
    assign stall_md = d_md_valid & (start | mdu_busy | shadow_busy);
    assign load_val = is_div(e_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    // Flush does not gate the load: the MDU has already sampled this cycle's start.
    mdu_shadow_cnt #(
        .CNT_W(CNT_W)
    ) u_shadow_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (start),
        .load_val(load_val),
        .busy    (shadow_busy),
        .restart (restart)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sync <= 1'b0;
        end else if ((shadow_busy != mdu_busy) || restart) begin
            err_sync <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: timestamp-based MDU/issue reference model, directed scenarios plus random traffic.
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_md_valid;
    logic [3:0] d_md_op;
    logic       d_advance;
    logic       e_flush;
    logic       mdu_busy;
    logic [3:0] md_op;
    logic       start;
    logic       stall_md;
    logic       err_sync;

    mdu_issue_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .d_md_valid(d_md_valid),
        .d_md_op   (d_md_op),
        .d_advance (d_advance),
        .e_flush   (e_flush),
        .mdu_busy  (mdu_busy),
        .md_op     (md_op),
        .start     (start),
        .stall_md  (stall_md),
        .err_sync  (err_sync)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: E contents plus "last busy cycle" timestamps for the shadow and the MDU.
    int         cyc = 0;
    int         sh_last;
    int         mdu_last;
    bit         early;
    bit         m_vld;
    logic [3:0] m_op;
    bit         m_err;
    logic [3:0] exp_md_op;
    bit         exp_start, exp_stall, exp_err, sb;

    function automatic int lat_of(input logic [3:0] op);
        return (op == DIV || op == DIVU) ? 10 : 5;
    endfunction

    task automatic model_reset();
        m_vld = 0; m_op = MD_NOP; m_err = 0;
        sh_last = -1; mdu_last = -1; early = 0;
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input bit adv, input bit fl);
        d_md_valid = v; d_md_op = op; d_advance = adv; e_flush = fl;
        mdu_busy   = (cyc <= mdu_last);
        sb         = (cyc <= sh_last);
        exp_md_op  = m_vld ? m_op : MD_NOP;
        exp_start  = m_vld && (m_op <= 4'd3);
        exp_stall  = v && (exp_start || mdu_busy || sb);
        exp_err    = m_err;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        if (sb != mdu_busy) m_err = 1;
        if (exp_start && sb) m_err = 1;
        if (exp_start && !sb) sh_last = cyc + lat_of(m_op);
        if (exp_start && !mdu_busy) mdu_last = cyc + lat_of(m_op) - (early ? 1 : 0);
        if (e_flush || exp_stall) begin
            m_vld = 0; m_op = MD_NOP;
        end else if (d_advance) begin
            m_vld = d_md_valid; m_op = d_md_valid ? d_md_op : MD_NOP;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 0;
        model_reset();
        d_md_valid = 0; d_md_op = MD_NOP; d_advance = 0; e_flush = 0; mdu_busy = 0;
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        d_md_valid = 1; d_md_op = MULT; d_advance = 1; e_flush = 0; mdu_busy = 0;
        #1;
        checks++;
        if ({md_op, start, stall_md, err_sync} !== {MD_NOP, 3'b000}) begin
            failures++;
            $display("FAIL reset_state: md_op=%h start=%b stall=%b err=%b, expected f 0 0 0",
                     md_op, start, stall_md, err_sync);
        end
        d_md_valid = 0; d_advance = 0;
    endtask

    task automatic test_mult_mflo();
        int stalls = 0, starts = 0, mflo_seen = 0;
        bit sent = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) drive(1, MULT, 1, 0);
            else if (!sent) drive(1, MFLO, 1, 0);
            else drive(0, MD_NOP, 1, 0);
            checks++;
            if ({md_op, start, stall_md, err_sync} !== {exp_md_op, exp_start, exp_stall, exp_err}) begin
                failures++;
                $display("FAIL mult_mflo k=%0d: md_op=%h start=%b stall=%b err=%b, expected %h %b %b %b",
                         k, md_op, start, stall_md, err_sync, exp_md_op, exp_start, exp_stall, exp_err);
            end
            if (stall_md) stalls++;
            if (start) begin
                starts++;
                checks++;
                if (md_op !== MULT) begin
                    failures++;
                    $display("FAIL mult_start_op: md_op=%h, expected 0", md_op);
                end
            end
            if (md_op == MFLO) mflo_seen++;
            if (k > 0 && !sent && !exp_stall) sent = 1;
            advance();
        end
        checks++;
        if (stalls != 6 || starts != 1 || mflo_seen != 1 || err_sync !== 1'b0) begin
            failures++;
            $display("FAIL mult_mflo_summary: stalls=%0d starts=%0d mflo=%0d err=%b, expected 6 1 1 0",
                     stalls, starts, mflo_seen, err_sync);
        end
    endtask

    task automatic test_divu_alu_mthi();
        int mthi_stalls = 0, mthi_seen = 0;
        bit sent = 0;
        for (int k = 0; k < 18; k++) begin
            if (k == 0) drive(1, DIVU, 1, 0);
            else if (k == 1) drive(0, MD_NOP, 1, 0);
            else if (!sent) drive(1, MTHI, 1, 0);
            else drive(0, MD_NOP, 1, 0);
            checks++;
            if ({md_op, start, stall_md, err_sync} !== {exp_md_op, exp_start, exp_stall, exp_err}) begin
                failures++;
                $display("FAIL divu_mthi k=%0d: md_op=%h start=%b stall=%b err=%b, expected %h %b %b %b",
                         k, md_op, start, stall_md, err_sync, exp_md_op, exp_start, exp_stall, exp_err);
            end
            if (k >= 2 && !sent && stall_md) mthi_stalls++;
            if (md_op == MTHI) mthi_seen++;
            if (k >= 2 && !sent && !exp_stall) sent = 1;
            advance();
        end
        checks++;
        if (mthi_stalls != 10 || mthi_seen != 1) begin
            failures++;
            $display("FAIL divu_mthi_summary: mthi_stalls=%0d md_op6_count=%0d, expected 10 1",
                     mthi_stalls, mthi_seen);
        end
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int k = 0; k < 20; k++) begin
            drive(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
            checks++;
            if (md_op !== MD_NOP || start !== 1'b0) begin
                failures++; bad++;
                $display("FAIL idle k=%0d: md_op=%h start=%b, expected f 0", k, md_op, start);
            end
            advance();
        end
    endtask

    task automatic test_flush_div();
        int stalls_after = 0;
        bit sent = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) drive(1, DIV, 1, 0);
            else if (k == 1) drive(1, MTLO, 1, 1);
            else if (!sent) drive(1, MTLO, 1, 0);
            else drive(0, MD_NOP, 1, 0);
            checks++;
            if ({md_op, start, stall_md, err_sync} !== {exp_md_op, exp_start, exp_stall, exp_err}) begin
                failures++;
                $display("FAIL flush_div k=%0d: md_op=%h start=%b stall=%b err=%b, expected %h %b %b %b",
                         k, md_op, start, stall_md, err_sync, exp_md_op, exp_start, exp_stall, exp_err);
            end
            if (k == 2) begin
                checks++;
                if (md_op !== MD_NOP) begin
                    failures++;
                    $display("FAIL flush_clears_e: md_op=%h, expected f", md_op);
                end
            end
            if (k >= 2 && !sent && stall_md) stalls_after++;
            if (k >= 2 && !sent && !exp_stall) sent = 1;
            advance();
        end
        checks++;
        if (stalls_after != 10) begin
            failures++;
            $display("FAIL flush_div_stalls: got %0d, expected 10", stalls_after);
        end
    endtask

    task automatic test_reset_mid();
        int stalls = 0;
        bit sent = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1, (k == 0) ? MULT : MFLO, 1, 0);
            checks++;
            if ({md_op, start, stall_md, err_sync} !== {exp_md_op, exp_start, exp_stall, exp_err}) begin
                failures++;
                $display("FAIL reset_mid k=%0d: md_op=%h start=%b stall=%b err=%b, expected %h %b %b %b",
                         k, md_op, start, stall_md, err_sync, exp_md_op, exp_start, exp_stall, exp_err);
            end
            if (k < 4) advance();
        end
        // Shadow count is 3 here; the MDU shares the reset net, so its Busy drops too.
        reset = 0; mdu_busy = 0;
        #1;
        checks++;
        if ({md_op, start, stall_md, err_sync} !== {MD_NOP, 3'b000}) begin
            failures++;
            $display("FAIL reset_mid_outputs: md_op=%h start=%b stall=%b err=%b, expected f 0 0 0",
                     md_op, start, stall_md, err_sync);
        end
        model_reset();
        @(negedge clk);
        reset = 1;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) drive(1, MULT, 1, 0);
            else if (!sent) drive(1, MFLO, 1, 0);
            else drive(0, MD_NOP, 1, 0);
            checks++;
            if ({md_op, start, stall_md, err_sync} !== {exp_md_op, exp_start, exp_stall, exp_err}) begin
                failures++;
                $display("FAIL reset_reissue k=%0d: md_op=%h start=%b stall=%b err=%b, expected %h %b %b %b",
                         k, md_op, start, stall_md, err_sync, exp_md_op, exp_start, exp_stall, exp_err);
            end
            if (stall_md) stalls++;
            if (k > 0 && !sent && !exp_stall) sent = 1;
            advance();
        end
        checks++;
        if (stalls != 6) begin
            failures++;
            $display("FAIL reset_reissue_stalls: got %0d, expected 6", stalls);
        end
    endtask

    task automatic test_busy_early();
        early = 1;
        for (int k = 0; k < 14; k++) begin
            drive((k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), (k == 0) ? MULTU : MFHI, 1, 0);
            checks++;
            if ({md_op, start, stall_md, err_sync} !== {exp_md_op, exp_start, exp_stall, exp_err}) begin
                failures++;
                $display("FAIL busy_early k=%0d: md_op=%h start=%b stall=%b err=%b, expected %h %b %b %b",
                         k, md_op, start, stall_md, err_sync, exp_md_op, exp_start, exp_stall, exp_err);
            end
            advance();
        end
        checks++;
        if (err_sync !== 1'b1) begin
            failures++;
            $display("FAIL busy_early_sticky: err_sync=%b, expected 1", err_sync);
        end
        apply_reset();
        #1;
        checks++;
        if (err_sync !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared_by_reset: err_sync=%b, expected 0", err_sync);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) == 0));
            checks++;
            if ({md_op, start, stall_md, err_sync} !== {exp_md_op, exp_start, exp_stall, exp_err}) begin
                failures++;
                $display("FAIL random k=%0d: md_op=%h start=%b stall=%b err=%b, expected %h %b %b %b",
                         k, md_op, start, stall_md, err_sync, exp_md_op, exp_start, exp_stall, exp_err);
            end
            advance();
        end
    endtask

    initial begin
        reset = 0;
        d_md_valid = 0; d_md_op = MD_NOP; d_advance = 0; e_flush = 0; mdu_busy = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_mult_mflo();
        test_divu_alu_mthi();
        test_idle();
        test_flush_div();
        test_reset_mid();
        test_busy_early();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Initiator side of the E-stage multiply/divide unit's start/MDOp/Busy interface.
- Holds the E-stage copy of the MD-class opcode and drives the MDU's opcode and start inputs.
- Keeps a shadow latency counter that mirrors the MDU's Busy, and raises the D-stage stall for MD-class instructions while an operation is in flight.
- Flags any divergence between the shadow counter and the MDU's reported Busy.

Parameters:
- MULT_LAT, 5, Busy-high cycles after a MULT/MULTU start.
- DIV_LAT, 10, Busy-high cycles after a DIV/DIVU start.
- CNT_W, 4, shadow counter width; must hold DIV_LAT.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- d_md_valid  in  1  D-stage instruction is MD-class (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).
- d_md_op  in  4  D-stage MD opcode: MULT=0, MULTU=1, DIV=2, DIVU=3, MFHI=4, MFLO=5, MTHI=6, MTLO=7.
- d_advance  in  1  pipeline moves D→E this cycle, with other hazards already resolved.
- e_flush  in  1  insert a bubble into E at the next edge.
- mdu_busy  in  1  Busy output of the MDU.
- md_op  out  4  opcode to the MDU; NOP code 4'hF whenever E holds no MD instruction.
- start  out  1  to the MDU; high while E holds MULT/MULTU/DIV/DIVU.
- stall_md  out  1  stall D/F, bubble E.
- err_sync  out  1  sticky: shadow busy disagreed with mdu_busy.

Behaviour:
- Reset (reset=0, asynchronous): e_vld=0, e_op=4'hF, shadow cnt=0, err_sync=0.
  - Hence md_op=4'hF, start=0, stall_md=0.
  - A reset mid-operation abandons the operation; the MDU is reset by the same net.
- md_op idle code: it must never idle at 0, because the MDU acts on MDOp whenever it is idle and 0 decodes as MULT.
- E register update, priority order, evaluated at each rising edge:
  1. e_flush=1 → e_vld=0, e_op=4'hF.
  2. stall_md=1 → bubble (e_vld=0, e_op=4'hF).
  3. d_advance=1 → e_vld=d_md_valid; e_op=d_md_valid ? d_md_op : 4'hF.
  4. Otherwise hold.
- Combinational outputs:
  - md_op = e_vld ? e_op : 4'hF.
  - start = e_vld & (e_op ≤ 3).
  - stall_md = d_md_valid & (start | mdu_busy | shadow_busy), where shadow_busy = (cnt ≠ 0).
  - mfhi/mflo/mthi/mtlo stall the same way as mult/div.
- Shadow counter:
  - Edge with start=1 and cnt=0: cnt ← MULT_LAT for op 0/1, DIV_LAT for op 2/3.
  - Else if cnt≠0: cnt ← cnt−1.
  - Busy therefore asserts one cycle after start, and cnt≠0 exactly while the MDU's Busy is high (5 or 10 cycles).
  - start with cnt≠0 is illegal and prevented by stall_md; if it occurs, ignore the reload and set err_sync.
- Flush interaction: e_flush does not cancel a start already presented this cycle. The MDU has sampled it, so the shadow counter loads regardless.
- err_sync: set at any edge where shadow_busy ≠ mdu_busy, or on the illegal restart above. Cleared only by reset.
- Latency: start appears in the cycle after the D→E edge; an MD instruction in D right behind a mult waits 1 cycle plus MULT_LAT cycles.
- No internal state other than the E register, cnt and err_sync.

Decomposition:
- Shared package (mdu_pkg) holds:
  - the opcode constants MULT..MTLO;
  - MD_NOP=4'hF;
  - the default MULT_LAT/DIV_LAT;
  - an is_muldiv(op) function.
  - The MDU and this block both import it.
- One natural sub-module: mdu_shadow_cnt (load/decrement counter plus busy flag), instantiated once.

Test Plan:
- MULT then MFLO back-to-back in D → start high 1 cycle with md_op=0; stall_md high 6 cycles (1 + MULT_LAT); MFLO reaches E once mdu_busy=0; err_sync=0.
- DIVU, independent ALU op, then MTHI → ALU op is not stalled; MTHI stalls until cnt reaches 0, i.e. 11 cycles after DIVU entered E; md_op=6 appears exactly once.
- No MD instructions for 20 cycles → md_op=4'hF and start=0 on every cycle; the MDU model's HI/LO stay unchanged.
- e_flush asserted in the same cycle as a DIV start → E clears next edge; cnt still loads 10; an MD op in D stalls 10 cycles.
- reset pulled low at cnt=3 during a MULT → outputs return to reset values immediately; the next MULT issues normally with cnt=5.
- MDU model forced to drop Busy one cycle early → err_sync=1 at that edge and stays high until reset.
